wrr_arb: RTL and testbench

//  Weighted round-robin arbiter. Successor to the fixed-priority/RR arbiter.
//  N requesters, per-channel credit weights, rotating pointer, hold-until-release.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_prio_enc.sv | 36 +++
 rtl/wrr_arb.sv | 187 ++++++++++++++++++
 tb/tb_wrr_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, GRANT)
//   eff_weight  : maps a programmed weight of 0 to an effective weight of 1
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest weight field eff_weight() handles; callers cast to/from their width.
  localparam int unsigned EFF_W = 16;

  function automatic logic [EFF_W-1:0] eff_weight(input logic [EFF_W-1:0] w);
    return (w == '0) ? EFF_W'(1) : w;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational rotating-start priority encoder.
// Picks the first set bit of vec at or after index start, wrapping around.
//   vec    in  N      candidate vector
//   start  in  ID_W   index searched first (must be < N)
//   onehot out N      selected bit, zero when nothing set
//   id     out ID_W   index of selected bit, 0 when nothing set
//   found  out 1      |vec
module rr_prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [ID_W-1:0] start,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] id,
  output logic            found
);

  always_comb begin
    int unsigned idx;
    onehot = '0;
    id     = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(unsigned'(start)) + k;
      if (idx >= N) idx = idx - N;
      if (!found && vec[idx[ID_W-1:0]]) begin
        found                   = 1'b1;
        onehot[idx[ID_W-1:0]]   = 1'b1;
        id                      = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter with hold-until-release and registered grant.
// Each requester owns a credit counter reloaded from its weight when no
// requester with credit remains; the winner is the first eligible channel at
// or after a rotating pointer.
// Optional feature macro ARB_TIMEOUT_EN: a tenure counter revokes the owner
// after max_hold grant cycles when another requester is waiting.
//   clk        in   clock
//   rst_n      in   synchronous reset, active low
//   req        in   NUM_REQS request lines, held for the whole tenure
//   weight     in   NUM_REQS*WEIGHT_W grants per round (0 acts as 1)
//   max_hold   in   TIMEOUT_W tenure limit, 0 = unlimited (timeout build only)
//   gnt        out  one-hot or zero grant, registered
//   gnt_id     out  index of granted channel, 0 when idle
//   gnt_valid  out  |gnt
//   gnt_new    out  pulse on first cycle of each new grant
//   timeout    out  pulse with gnt_new on a forced handover
module wrr_arb
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQS-1:0]          req,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weight,
  input  logic [TIMEOUT_W-1:0]         max_hold,
  output logic [NUM_REQS-1:0]          gnt,
  output logic [$clog2(NUM_REQS)-1:0]  gnt_id,
  output logic                         gnt_valid,
  output logic                         gnt_new,
  output logic                         timeout
);

  localparam int unsigned ID_W = $clog2(NUM_REQS);

  arb_state_e                         state_q, state_d;
  logic [NUM_REQS-1:0]                gnt_q, gnt_d;
  logic [ID_W-1:0]                    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic                               gnt_new_q, gnt_new_d;
  logic [NUM_REQS-1:0][WEIGHT_W-1:0]  credit_q, credit_d;

  logic                revoke;
  logic                do_arb, arb_go;
  logic [NUM_REQS-1:0] cand, elig;
  logic [NUM_REQS-1:0] elig_oh, req_oh, win_oh;
  logic [ID_W-1:0]     elig_id, req_id, win;
  logic                elig_found, req_found;

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tenure_q, tenure_d;
  logic                 timeout_q;

  assign revoke = (state_q == GRANT) && (|(req & gnt_q)) && (max_hold != '0) &&
                  (tenure_q == max_hold) && (|(req & ~gnt_q));

  always_comb begin
    tenure_d = tenure_q;
    if (arb_go) begin
      tenure_d = TIMEOUT_W'(1);
    end else if (state_q == GRANT && tenure_q != '1) begin
      tenure_d = tenure_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tenure_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      tenure_q  <= tenure_d;
      timeout_q <= revoke;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^max_hold;
  assign revoke          = 1'b0;
  assign timeout         = 1'b0;
`endif

  // On a forced handover the current owner is excluded from both searches.
  assign cand = req & ~({NUM_REQS{revoke}} & gnt_q);
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      elig[i] = cand[i] && (credit_q[i] != '0);
    end
  end

  rr_prio_enc #(.N(NUM_REQS), .ID_W(ID_W)) u_enc_elig (
    .vec    (elig),
    .start  (ptr_q),
    .onehot (elig_oh),
    .id     (elig_id),
    .found  (elig_found)
  );

  rr_prio_enc #(.N(NUM_REQS), .ID_W(ID_W)) u_enc_req (
    .vec    (cand),
    .start  (ptr_q),
    .onehot (req_oh),
    .id     (req_id),
    .found  (req_found)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    gnt_new_d = 1'b0;
    do_arb    = 1'b0;
    win       = '0;
    win_oh    = '0;

    case (state_q)
      IDLE: do_arb = |req;
      GRANT: begin
        if (!(|(req & gnt_q))) begin
          // Owner released: hand over directly if anyone else is asking.
          if (|req) begin
            do_arb = 1'b1;
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            state_d  = IDLE;
          end
        end else if (revoke) begin
          do_arb = 1'b1;
        end
      end
      default: ;
    endcase

    arb_go = do_arb && req_found;

    if (arb_go) begin
      if (elig_found) begin
        win    = elig_id;
        win_oh = elig_oh;
      end else begin
        // Round exhausted: refill every channel, then pick by request only.
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
          credit_d[i] = WEIGHT_W'(eff_weight(EFF_W'(weight[i*WEIGHT_W +: WEIGHT_W])));
        end
        win    = req_id;
        win_oh = req_oh;
      end
      if (credit_d[win] != '0) credit_d[win] = credit_d[win] - WEIGHT_W'(1);
      ptr_d     = (win == ID_W'(NUM_REQS - 1)) ? '0 : win + ID_W'(1);
      gnt_d     = win_oh;
      gnt_id_d  = win;
      gnt_new_d = 1'b1;
      state_d   = GRANT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      gnt_new_q <= 1'b0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      gnt_new_q <= gnt_new_d;
      credit_q  <= credit_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign gnt_new   = gnt_new_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Self-checking bench for wrr_arb (4 requesters, 4-bit weights, 8-bit tenure).
// Hand-written vector table for reset/hold/mid-op reset, a hand sequence for
// tenure timeout, and model-checked WRR and random traffic.
// Honours ARB_TIMEOUT_EN to select the expected timeout behaviour.
module tb_wrr_arb;

  localparam int N = 4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [7:0]  max_hold;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_valid, gnt_new, timeout;

  always #5 clk = ~clk;

  wrr_arb #(.NUM_REQS(4), .WEIGHT_W(4), .TIMEOUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .weight    (weight),
    .max_hold  (max_hold),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .gnt_new   (gnt_new),
    .timeout   (timeout)
  );

  // Reference model state: owner -1 means no grant.
  int m_cred[N];
  int m_ptr, m_owner, m_ten;
  bit m_new, m_tmo;

  int n_vec, n_err;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       nw;
  } vec_t;

  vec_t tbl[22];

  task automatic m_arb(input int ex);
    int win;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (win < 0 && req[i] && i != ex && m_cred[i] > 0) win = i;
    end
    if (win < 0) begin
      for (int i = 0; i < N; i++) begin
        int w;
        w = int'(weight[i*4 +: 4]);
        m_cred[i] = (w == 0) ? 1 : w;
      end
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && req[i] && i != ex) win = i;
      end
    end
    m_cred[win] = m_cred[win] - 1;
    m_ptr   = (win + 1) % N;
    m_owner = win;
    m_ten   = 1;
    m_new   = 1'b1;
  endtask

  task automatic m_step();
    m_new = 1'b0;
    m_tmo = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_cred[i] = 0;
      m_ptr = 0; m_owner = -1; m_ten = 0;
    end else if (m_owner < 0) begin
      if (req != 4'h0) m_arb(-1);
    end else if (!req[m_owner]) begin
      if (req != 4'h0) m_arb(-1);
      else m_owner = -1;
    end else if (TMO_EN && max_hold != 8'd0 && m_ten == int'(max_hold) &&
                 (req & ~(4'b0001 << m_owner)) != 4'h0) begin
      m_tmo = 1'b1;
      m_arb(m_owner);
    end else if (m_ten < 255) begin
      m_ten++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic en, input logic et);
    logic [8:0] act, exp;
    act = {gnt, gnt_id, gnt_valid, gnt_new, timeout};
    exp = {eg, eid, (eg != 4'h0), en, et};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got gnt=%b id=%0d valid=%b new=%b tmo=%b, want gnt=%b id=%0d valid=%b new=%b tmo=%b",
               name, $time, gnt, gnt_id, gnt_valid, gnt_new, timeout,
               eg, eid, (eg != 4'h0), en, et);
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'h0 : (4'b0001 << m_owner);
  endfunction

  task automatic check_model(input string name);
    check(name, m_gnt(), (m_owner < 0) ? 2'd0 : 2'(m_owner), m_new, m_tmo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    m_ptr = 0; m_owner = -1; m_ten = 0; m_new = 0; m_tmo = 0;
    for (int i = 0; i < N; i++) m_cred[i] = 0;

    // rst_n, req -> gnt, id, gnt_new (outputs after the edge that samples the inputs)
    tbl[0]  = '{1'b0, 4'hF, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h1, 2'd0, 1'b1};  // reload, ch0 wins from ptr 0
    tbl[3]  = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b1};
    for (int v = 5; v <= 13; v++) tbl[v] = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b0};
    tbl[14] = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[15] = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b1};  // ch2 out of credit -> reload
    tbl[16] = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b0};
    tbl[17] = '{1'b0, 4'h4, 4'h0, 2'd0, 1'b0};  // mid-op reset aborts grant
    tbl[18] = '{1'b1, 4'h6, 4'h2, 2'd1, 1'b1};  // ptr back at 0 -> ch1 first
    tbl[19] = '{1'b1, 4'h6, 4'h2, 2'd1, 1'b0};
    tbl[20] = '{1'b1, 4'h4, 4'h4, 2'd2, 1'b1};  // ch1 releases, direct handover
    tbl[21] = '{1'b1, 4'h0, 4'h0, 2'd0, 1'b0};

    rst_n = 1'b0; req = 4'h0; weight = 16'h1111; max_hold = 8'd0;

    for (int v = 0; v < 22; v++) begin
      rst_n = tbl[v].rst_n;
      req   = tbl[v].req;
      cycle();
      check($sformatf("tbl%0d", v), tbl[v].gnt, tbl[v].id, tbl[v].nw, 1'b0);
    end

    // Tenure timeout: two requesters held, max_hold = 5.
    rst_n = 1'b0; req = 4'h0;
    cycle();
    check("tmo_rst", 4'h0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1; weight = 16'h1111; max_hold = 8'd5; req = 4'b0011;
    for (int c = 0; c < 22; c++) begin
      logic [3:0] eg;
      logic       en, et;
      cycle();
      if (TMO_EN) begin
        eg = ((c / 5) % 2 == 0) ? 4'b0001 : 4'b0010;
        en = (c % 5 == 0);
        et = en && (c > 0);
      end else begin
        eg = 4'b0001;
        en = (c == 0);
        et = 1'b0;
      end
      check($sformatf("tmo_c%0d", c), eg, (eg == 4'b0010) ? 2'd1 : 2'd0, en, et);
    end
    req = 4'h0;
    cycle();
    check_model("tmo_end");

    // WRR: weights {1,1,1,3}, every channel asks again right after its 1-cycle tenure.
    weight = 16'h3111; max_hold = 8'd0;
    for (int c = 0; c < 24; c++) begin
      req = 4'hF & ~m_gnt();
      cycle();
      check_model($sformatf("wrr_c%0d", c));
    end

    // Random traffic against the model.
    req = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (c % 50 == 0) begin
        weight   = 16'($urandom);
        max_hold = 8'($urandom_range(0, 7));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      cycle();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
